// File: rtl/cpu_6502_rmw_seq.sv
// rtl/cpu_6502_rmw_seq.sv - 6502 read-modify-write memory instruction sequencer
// Fetches the operand, drives the shared ALU, writes back and reports C/Z/N updates.
module cpu_6502_rmw_seq #(
  parameter bit P_DUMMY_WRITE = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [15:0] i_addr,
  input  logic        i_c,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [15:0] o_bus_addr,
  output logic [7:0]  o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [7:0]  i_bus_rdata,
  output logic [3:0]  o_alu_func,
  output logic [7:0]  o_alu_left,
  output logic [7:0]  o_alu_right,
  output logic        o_alu_c,
  input  logic [7:0]  i_alu_q,
  input  logic        i_alu_c,
  input  logic        i_alu_z,
  input  logic        i_alu_n,
  output logic        o_flag_c_we,
  output logic        o_flag_nz_we,
  output logic        o_c,
  output logic        o_z,
  output logic        o_n
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_MOD   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic        c_q, c_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  res_q, res_d;
  logic        res_c_q, res_c_d;
  logic        res_z_q, res_z_d;
  logic        res_n_q, res_n_d;
  logic        accept;
  logic        mod_exit;

  assign accept   = i_start && (i_op <= 3'd5);
  // Without the dummy write, MOD is a single bus-idle cycle.
  assign mod_exit = !P_DUMMY_WRITE || i_bus_ack;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      op_q    <= 3'd0;
      c_q     <= 1'b0;
      data_q  <= 8'h00;
      res_q   <= 8'h00;
      res_c_q <= 1'b0;
      res_z_q <= 1'b0;
      res_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      c_q     <= c_d;
      data_q  <= data_d;
      res_q   <= res_d;
      res_c_q <= res_c_d;
      res_z_q <= res_z_d;
      res_n_q <= res_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  if (i_bus_ack) state_d = S_MOD;
      S_MOD:   if (mod_exit) state_d = S_WRITE;
      S_WRITE: if (i_bus_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    op_d    = op_q;
    c_d     = c_q;
    data_d  = data_q;
    res_d   = res_q;
    res_c_d = res_c_q;
    res_z_d = res_z_q;
    res_n_d = res_n_q;
    if (state_q == S_IDLE && accept) begin
      addr_d = i_addr;
      op_d   = i_op;
      c_d    = i_c;
    end
    if (state_q == S_READ && i_bus_ack) begin
      data_d = i_bus_rdata;
    end
    if (state_q == S_MOD && mod_exit) begin
      res_d   = i_alu_q;
      res_c_d = i_alu_c;
      res_z_d = i_alu_z;
      res_n_d = i_alu_n;
    end
  end

  always_comb begin
    o_busy       = (state_q != S_IDLE);
    o_done       = 1'b0;
    o_bus_req    = 1'b0;
    o_bus_we     = 1'b0;
    o_bus_addr   = 16'h0000;
    o_bus_wdata  = 8'h00;
    o_alu_func   = 4'hF;
    o_alu_left   = 8'h00;
    o_alu_right  = 8'h00;
    o_alu_c      = 1'b0;
    o_flag_c_we  = 1'b0;
    o_flag_nz_we = 1'b0;
    o_c          = 1'b0;
    o_z          = 1'b0;
    o_n          = 1'b0;
    case (state_q)
      S_READ: begin
        o_bus_req  = 1'b1;
        o_bus_addr = addr_q;
      end
      S_MOD: begin
        o_bus_req   = P_DUMMY_WRITE;
        o_bus_we    = P_DUMMY_WRITE;
        o_bus_addr  = P_DUMMY_WRITE ? addr_q : 16'h0000;
        o_bus_wdata = P_DUMMY_WRITE ? data_q : 8'h00;
        o_alu_left  = data_q;
        o_alu_c     = c_q;
        case (op_q)
          3'd0:    o_alu_func = 4'h8;
          3'd1:    o_alu_func = 4'h9;
          3'd2:    o_alu_func = 4'hA;
          3'd3:    o_alu_func = 4'hB;
          3'd4:    o_alu_func = 4'h5;
          3'd5:    o_alu_func = 4'h7;
          default: o_alu_func = 4'hF;
        endcase
      end
      S_WRITE: begin
        o_bus_req   = 1'b1;
        o_bus_we    = 1'b1;
        o_bus_addr  = addr_q;
        o_bus_wdata = res_q;
      end
      S_DONE: begin
        o_done       = 1'b1;
        o_flag_nz_we = 1'b1;
        // Only the shifts and rotates touch carry; INC/DEC leave it alone.
        o_flag_c_we  = (op_q <= 3'd3);
        o_c          = res_c_q;
        o_z          = res_z_q;
        o_n          = res_n_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_6502_rmw_seq.sv
// tb/tb_cpu_6502_rmw_seq.sv - randomized self-checking bench for cpu_6502_rmw_seq
// Instance 0 emits the dummy write, instance 1 replaces it with a bus-idle cycle.
module tb_cpu_6502_rmw_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [1:0]  ack = 2'b00;
  logic [2:0]  in_op = 3'd0;
  logic [15:0] in_addr = 16'h0000;
  logic        in_c = 1'b0;
  logic [7:0]  in_rdata = 8'h00;

  logic [1:0]  busy, done, req, we, alu_ci, alu_co, alu_z, alu_n, cwe, nzwe, oc, oz, on;
  logic [15:0] bus_addr [2];
  logic [7:0]  wdata [2];
  logic [3:0]  alu_func [2];
  logic [7:0]  alu_left [2];
  logic [7:0]  alu_right [2];
  logic [7:0]  alu_q [2];

  int nchk = 0;
  int nerr = 0;

  logic [24:0] tr_q[$];
  int          done_cyc;
  bit          stable_ok;
  logic        got_c, got_z, got_n, got_cwe, got_nzwe;

  always #5 clk = ~clk;

  // Behavioural ALU driven by function code.
  function automatic logic [8:0] alu_model(input logic [3:0] f, input logic [7:0] a, input logic ci);
    int t;
    case (f)
      4'h8:    t = a * 2;
      4'h9:    t = (a % 2) * 256 + a / 2;
      4'hA:    t = a * 2 + ci;
      4'hB:    t = (a % 2) * 256 + a / 2 + ci * 128;
      4'h5:    t = (a + 1) % 256;
      4'h7:    t = (a + 255) % 256;
      default: t = 0;
    endcase
    return t[8:0];
  endfunction

  // Instruction-level reference: {carry_out, result}.
  function automatic logic [8:0] ref_rmw(input logic [2:0] op, input logic [7:0] d, input logic ci);
    logic [7:0] r;
    logic co;
    co = 1'b0;
    case (op)
      3'd0:    begin r = {d[6:0], 1'b0}; co = d[7]; end
      3'd1:    begin r = {1'b0, d[7:1]}; co = d[0]; end
      3'd2:    begin r = {d[6:0], ci};   co = d[7]; end
      3'd3:    begin r = {ci, d[7:1]};   co = d[0]; end
      3'd4:    r = d + 8'd1;
      default: r = d - 8'd1;
    endcase
    return {co, r};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cpu_6502_rmw_seq #(.P_DUMMY_WRITE(g == 0)) u_dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_start     (start[g]),
      .i_op        (in_op),
      .i_addr      (in_addr),
      .i_c         (in_c),
      .o_busy      (busy[g]),
      .o_done      (done[g]),
      .o_bus_req   (req[g]),
      .o_bus_we    (we[g]),
      .o_bus_addr  (bus_addr[g]),
      .o_bus_wdata (wdata[g]),
      .i_bus_ack   (ack[g]),
      .i_bus_rdata (in_rdata),
      .o_alu_func  (alu_func[g]),
      .o_alu_left  (alu_left[g]),
      .o_alu_right (alu_right[g]),
      .o_alu_c     (alu_ci[g]),
      .i_alu_q     (alu_q[g]),
      .i_alu_c     (alu_co[g]),
      .i_alu_z     (alu_z[g]),
      .i_alu_n     (alu_n[g]),
      .o_flag_c_we (cwe[g]),
      .o_flag_nz_we(nzwe[g]),
      .o_c         (oc[g]),
      .o_z         (oz[g]),
      .o_n         (on[g])
    );
    assign {alu_co[g], alu_q[g]} = alu_model(alu_func[g], alu_left[g], alu_ci[g]);
    assign alu_z[g] = (alu_q[g] == 8'h00);
    assign alu_n[g] = alu_q[g][7];
  end

  // Runs one instruction on instance sel; the bus responder acks each request after `waits` cycles.
  task automatic run_op(input int sel, input logic [2:0] op, input logic [15:0] addr, input logic ci,
                        input logic [7:0] rd, input int waits, input bit poke);
    int wcnt;
    bit held;
    logic [15:0] pa;
    logic pw;
    logic [7:0] pd;
    tr_q.delete();
    stable_ok = 1'b1;
    done_cyc = -1;
    held = 1'b0;
    wcnt = 0;
    @(posedge clk); #1;
    in_op = op; in_addr = addr; in_c = ci; in_rdata = rd;
    start[sel] = 1'b1;
    for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start[sel] = 1'b0;
      ack[sel] = 1'b0;
      if (poke && cyc == 2) begin
        start[sel] = 1'b1; in_op = 3'd4; in_addr = ~addr; in_c = ~ci;
      end
      if (req[sel]) begin
        if (held && (bus_addr[sel] !== pa || we[sel] !== pw || wdata[sel] !== pd)) stable_ok = 1'b0;
        pa = bus_addr[sel]; pw = we[sel]; pd = wdata[sel]; held = 1'b1;
        if (wcnt == waits) begin
          ack[sel] = 1'b1;
          tr_q.push_back({we[sel], bus_addr[sel], we[sel] ? wdata[sel] : rd});
          wcnt = 0;
          held = 1'b0;
        end else begin
          wcnt++;
        end
      end else begin
        held = 1'b0;
      end
      if (done[sel]) begin
        done_cyc = cyc;
        got_c = oc[sel]; got_z = oz[sel]; got_n = on[sel];
        got_cwe = cwe[sel]; got_nzwe = nzwe[sel];
      end
    end
    start = 2'b00;
    ack = 2'b00;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      nchk++;
      if ({busy[g], done[g], req[g], we[g], bus_addr[g], wdata[g], alu_func[g], alu_left[g], alu_right[g],
           alu_ci[g], cwe[g], nzwe[g], oc[g], oz[g], on[g]} !==
          {4'b0000, 16'h0000, 8'h00, 4'hF, 8'h00, 8'h00, 6'b000000}) begin
        nerr++;
        $display("FAIL reset_state dut%0d: busy=%b req=%b addr=%h func=%h left=%h required all zero, func=f",
                 g, busy[g], req[g], bus_addr[g], alu_func[g], alu_left[g]);
      end
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_rmw_op(input string name, input int sel, input logic [2:0] op, input logic [15:0] addr,
                             input logic ci, input logic [7:0] rd, input int waits, input bit poke);
    logic [8:0] r;
    logic [24:0] exp_tr[$];
    int exp_done;
    r = ref_rmw(op, rd, ci);
    exp_tr.push_back({1'b0, addr, rd});
    if (sel == 0) exp_tr.push_back({1'b1, addr, rd});
    exp_tr.push_back({1'b1, addr, r[7:0]});
    exp_done = 4 + waits * exp_tr.size();
    run_op(sel, op, addr, ci, rd, waits, poke);
    nchk++;
    if (done_cyc != exp_done) begin
      nerr++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, done_cyc, exp_done);
    end
    nchk++;
    if (tr_q.size() != exp_tr.size()) begin
      nerr++;
      $display("FAIL %s bus_count: got %0d required %0d", name, tr_q.size(), exp_tr.size());
    end else begin
      for (int i = 0; i < exp_tr.size(); i++) begin
        nchk++;
        if (tr_q[i] !== exp_tr[i]) begin
          nerr++;
          $display("FAIL %s bus_txn%0d {we,addr,data}: got %h required %h", name, i, tr_q[i], exp_tr[i]);
        end
      end
    end
    nchk++;
    if ({got_nzwe, got_cwe, got_z, got_n} !== {1'b1, op <= 3'd3, r[7:0] == 8'h00, r[7]}) begin
      nerr++;
      $display("FAIL %s flags {nz_we,c_we,z,n}: got %b required %b", name,
               {got_nzwe, got_cwe, got_z, got_n}, {1'b1, op <= 3'd3, r[7:0] == 8'h00, r[7]});
    end
    if (op <= 3'd3) begin
      nchk++;
      if (got_c !== r[8]) begin
        nerr++;
        $display("FAIL %s carry: got %b required %b", name, got_c, r[8]);
      end
    end
    if (waits > 0) begin
      nchk++;
      if (!stable_ok) begin
        nerr++;
        $display("FAIL %s bus_stable: got unstable required stable", name);
      end
    end
    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        nchk++;
        if ({busy[sel], req[sel]} !== 2'b00) begin
          nerr++;
          $display("FAIL %s start_not_queued: busy/req=%b required 00", name, {busy[sel], req[sel]});
        end
      end
    end
  endtask

  task automatic test_bad_op();
    for (int k = 6; k < 8; k++) begin
      @(posedge clk); #1;
      in_op = 3'(k);
      start = 2'b11;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        start = 2'b00;
        nchk++;
        if ({busy, req} !== 4'b0000) begin
          nerr++;
          $display("FAIL bad_op%0d: busy=%b req=%b required 00 00", k, busy, req);
        end
      end
    end
  endtask

  task automatic test_spurious_ack();
    @(posedge clk); #1;
    ack = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      nchk++;
      if ({busy, req, done} !== 6'b000000) begin
        nerr++;
        $display("FAIL spurious_ack: busy=%b req=%b done=%b required 00 00 00", busy, req, done);
      end
    end
    ack = 2'b00;
  endtask

  task automatic test_abort();
    int reqs;
    @(posedge clk); #1;
    in_op = 3'd0; in_addr = 16'h1234; in_rdata = 8'h55; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    ack[0] = 1'b1;
    @(posedge clk); #1;
    ack[0] = 1'b0;
    nchk++;
    if ({req[0], we[0]} !== 2'b11) begin
      nerr++;
      $display("FAIL abort_reach_mod: req/we=%b required 11", {req[0], we[0]});
    end
    rstn = 1'b0;
    #1;
    nchk++;
    if ({busy[0], req[0]} !== 2'b00) begin
      nerr++;
      $display("FAIL abort_immediate: busy/req=%b required 00", {busy[0], req[0]});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    reqs = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (req[0] || busy[0]) reqs++;
    end
    nchk++;
    if (reqs != 0) begin
      nerr++;
      $display("FAIL abort_no_write: active cycles %0d required 0", reqs);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      test_rmw_op("random", int'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 16'($urandom),
                  1'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rmw_op("asl_0200", 0, 3'd0, 16'h0200, 1'b0, 8'h80, 0, 1'b0);
    test_rmw_op("ror_c1", 0, 3'd3, 16'h0310, 1'b1, 8'h01, 0, 1'b0);
    test_rmw_op("rol_c0", 0, 3'd2, 16'h0042, 1'b0, 8'h40, 0, 1'b0);
    test_rmw_op("inc_ff", 0, 3'd4, 16'hC000, 1'b1, 8'hFF, 0, 1'b0);
    test_rmw_op("dec_00", 0, 3'd5, 16'hFFFF, 1'b0, 8'h00, 0, 1'b0);
    test_rmw_op("asl_wait3", 0, 3'd0, 16'h0200, 1'b0, 8'hC3, 3, 1'b0);
    test_spurious_ack();
    test_rmw_op("lsr_nodummy", 1, 3'd1, 16'h0777, 1'b0, 8'h03, 0, 1'b0);
    test_rmw_op("busy_start", 0, 3'd1, 16'h5AA5, 1'b1, 8'h81, 1, 1'b1);
    test_rmw_op("busy_start_nd", 1, 3'd3, 16'h0101, 1'b0, 8'hFE, 0, 1'b1);
    test_bad_op();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
